// File: rtl/alu_mdu_if.sv
// Request/response bundle between operand fetch, the alu_mdu execute unit and writeback.
// Handshake: a transfer happens on a rising edge where valid && ready; the producer keeps
// its payload stable while valid is high and ready is low, and valid never depends on ready.
interface alu_mdu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            equal;
   logic            less_than;
   logic            less_than_unsigned;

   modport master (
      output in_valid, op, a, b, kill, out_ready,
      input  in_ready, out_valid, result, equal, less_than, less_than_unsigned
   );

   modport slave (
      input  in_valid, op, a, b, kill, out_ready,
      output in_ready, out_valid, result, equal, less_than, less_than_unsigned
   );
endinterface

// File: rtl/alu_mdu.sv
// Execute unit: single-cycle base ALU ops plus iterative radix-2 RV32M multiply/divide.
// One shared 2*XLEN accumulator serves both the shift-add multiplier and the restoring divider.
module alu_mdu #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   alu_mdu_if.slave   bus,
   output logic [1:0] dbg_state
);
   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [4:0]        op_r;
   logic              neg_r;
   logic [XLEN-1:0]   mag_b_r;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   result_r;
   logic              eq_r, lt_r, ltu_r;

   logic [SHW-1:0]    shamt;
   logic              is_iter, is_div, sgn_a, sgn_b, div_zero, div_ovf, special, neg_in;
   logic [XLEN-1:0]   mag_a, mag_b, alu_res;
   logic [XLEN:0]     mul_sum, trial;
   logic [2*XLEN-1:0] acc_nxt, prod_fix;
   logic [XLEN-1:0]   quo, rmd, iter_res;

   assign bus.in_ready           = (state == S_IDLE);
   assign bus.out_valid          = (state == S_DONE);
   assign bus.result             = result_r;
   assign bus.equal              = eq_r;
   assign bus.less_than          = lt_r;
   assign bus.less_than_unsigned = ltu_r;
   assign dbg_state              = state;

   // Operand decode and the single-cycle result, evaluated on the request inputs.
   always_comb begin
      shamt    = bus.b[SHW-1:0];
      is_iter  = (bus.op >= 5'd10) && (bus.op <= 5'd17);
      is_div   = (bus.op >= 5'd14) && (bus.op <= 5'd17);
      sgn_a    = (bus.op == 5'd11 || bus.op == 5'd12 || bus.op == 5'd14 || bus.op == 5'd16)
                 && bus.a[XLEN-1];
      sgn_b    = (bus.op == 5'd11 || bus.op == 5'd14 || bus.op == 5'd16) && bus.b[XLEN-1];
      mag_a    = sgn_a ? -bus.a : bus.a;
      mag_b    = sgn_b ? -bus.b : bus.b;
      neg_in   = (bus.op == 5'd16) ? sgn_a : (sgn_a ^ sgn_b);
      div_zero = is_div && (bus.b == '0);
      div_ovf  = (bus.op == 5'd14 || bus.op == 5'd16) && (bus.b == '1)
                 && (bus.a == {1'b1, {(XLEN-1){1'b0}}});
      special  = div_zero || div_ovf;
      alu_res  = '0;
      case (bus.op)
         5'd0:  alu_res = bus.a + bus.b;
         5'd1:  alu_res = bus.a - bus.b;
         5'd2:  alu_res = bus.a ^ bus.b;
         5'd3:  alu_res = bus.a | bus.b;
         5'd4:  alu_res = bus.a & bus.b;
         5'd5:  alu_res = bus.a << shamt;
         5'd6:  alu_res = bus.a >> shamt;
         5'd7:  alu_res = $signed(bus.a) >>> shamt;
         5'd8:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         5'd9:  alu_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
         5'd14: alu_res = div_zero ? '1 : bus.a;
         5'd15: alu_res = '1;
         5'd16: alu_res = div_zero ? bus.a : '0;
         5'd17: alu_res = bus.a;
         default: alu_res = '0;
      endcase
   end

   // One iteration step; the low half holds the multiplier (mul) or dividend/quotient (div).
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b_r} : '0);
      trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b_r};
      if (op_r >= 5'd14) begin
         if (!trial[XLEN]) acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else              acc_nxt = {acc[2*XLEN-2:0], 1'b0};
      end else begin
         acc_nxt = {mul_sum, acc[XLEN-1:1]};
      end
      prod_fix = neg_r ? -acc_nxt : acc_nxt;
      quo      = acc_nxt[XLEN-1:0];
      rmd      = acc_nxt[2*XLEN-1:XLEN];
      case (op_r)
         5'd10:               iter_res = prod_fix[XLEN-1:0];
         5'd11, 5'd12, 5'd13: iter_res = prod_fix[2*XLEN-1:XLEN];
         5'd14, 5'd15:        iter_res = neg_r ? -quo : quo;
         default:             iter_res = neg_r ? -rmd : rmd;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_r     <= '0;
         neg_r    <= 1'b0;
         mag_b_r  <= '0;
         acc      <= '0;
         result_r <= '0;
         eq_r     <= 1'b0;
         lt_r     <= 1'b0;
         ltu_r    <= 1'b0;
      end else if (bus.kill) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.in_valid) begin
               op_r  <= bus.op;
               eq_r  <= (bus.a == bus.b);
               lt_r  <= ($signed(bus.a) < $signed(bus.b));
               ltu_r <= (bus.a < bus.b);
               if (is_iter && !special) begin
                  state   <= S_BUSY;
                  cnt     <= CW'(XLEN);
                  neg_r   <= neg_in;
                  mag_b_r <= mag_b;
                  acc     <= {{XLEN{1'b0}}, mag_a};
               end else begin
                  result_r <= alu_res;
                  state    <= S_DONE;
               end
            end
            S_BUSY: begin
               acc <= acc_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  result_r <= iter_res;
                  state    <= S_DONE;
               end
            end
            S_DONE: if (bus.out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed bench for alu_mdu against an arithmetic reference model,
// with a scoreboard queue drained by an output monitor.
module tb_alu_mdu;
   localparam int XLEN = 32;
   localparam int W    = XLEN + 3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] dbg_state;
   int         n_vec = 0;
   int         n_err = 0;
   logic [W-1:0] exp_q[$];

   alu_mdu_if #(.XLEN(XLEN)) bus ();

   alu_mdu #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got time limit, want $finish");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: result from plain 64-bit arithmetic, then the three compare flags.
   function automatic logic [W-1:0] model(input logic [4:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
      logic [31:0] r;
      logic [63:0] p;
      logic [4:0]  sh;
      longint      sx, sy, uy;
      sh = y[4:0];
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      uy = longint'({32'b0, y});
      p  = '0;
      case (o)
         5'd0:  r = x + y;
         5'd1:  r = x - y;
         5'd2:  r = x ^ y;
         5'd3:  r = x | y;
         5'd4:  r = x & y;
         5'd5:  r = x << sh;
         5'd6:  r = x >> sh;
         5'd7:  r = 32'($signed(x) >>> sh);
         5'd8:  r = {31'b0, sx < sy};
         5'd9:  r = {31'b0, x < y};
         5'd10: begin p = 64'(sx * sy); r = p[31:0]; end
         5'd11: begin p = 64'(sx * sy); r = p[63:32]; end
         5'd12: begin p = 64'(sx * uy); r = p[63:32]; end
         5'd13: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
         5'd14: r = (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
         5'd15: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
         5'd16: r = (y == 0) ? x : 32'(sx % sy);
         5'd17: r = (y == 0) ? x : x % y;
         default: r = '0;
      endcase
      return {r, x == y, sx < sy, x < y};
   endfunction

   function automatic int exp_latency(input logic [4:0] o, input logic [31:0] x,
                                      input logic [31:0] y);
      if (o < 5'd10 || o > 5'd17) return 0;
      if (o >= 5'd14 && y == 0) return 0;
      if ((o == 5'd14 || o == 5'd16) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
      return XLEN;
   endfunction

   // Scoreboard monitor: a retirement is visible when out_valid && out_ready ahead of an edge.
   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got %h with no request pending", bus.result);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("result_flags",
                  {bus.result, bus.equal, bus.less_than, bus.less_than_unsigned}, e);
         end
      end
   end

   task automatic wait_ready();
      int guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) check("in_ready_timeout", 0, 1);
   endtask

   task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int hold);
      logic [W-1:0] e;
      int cyc, ready_hi, bad;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.op = o;
      bus.a  = x;
      bus.b  = y;
      e = model(o, x, y);
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op = 5'($urandom);
      bus.a  = $urandom;
      bus.b  = $urandom;
      cyc = 0;
      ready_hi = 0;
      while (!bus.out_valid && cyc < 100) begin
         if (bus.in_ready) ready_hi++;
         @(posedge clk); #1;
         cyc++;
         bus.a = $urandom;
         bus.b = $urandom;
      end
      check("latency", 64'(cyc), 64'(exp_latency(o, x, y)));
      check("in_ready_busy", 64'(ready_hi), 0);
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         bus.a  = $urandom;
         bus.b  = $urandom;
         bus.op = 5'($urandom);
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
             {bus.result, bus.equal, bus.less_than, bus.less_than_unsigned} !== e) bad++;
      end
      if (hold > 0) check("hold_stable", 64'(bad), 0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("retire_idle", {bus.in_ready, bus.out_valid}, 2'b10);
   endtask

   task automatic kill_busy(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      int seen;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.op = o;
      bus.a  = x;
      bus.b  = y;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.kill = 1'b1;
      bus.in_valid = 1'b1;
      bus.op = 5'd0;
      @(posedge clk); #1;
      check("kill_to_idle", {bus.in_ready, bus.out_valid}, 2'b10);
      // Still killing with a request pending in IDLE: it must not be taken.
      @(posedge clk); #1;
      bus.kill = 1'b0;
      bus.in_valid = 1'b0;
      check("kill_blocks_accept", {bus.in_ready, bus.out_valid, dbg_state}, 4'b1000);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      check("kill_no_output", 64'(seen), 0);
   endtask

   task automatic reset_busy();
      wait_ready();
      bus.in_valid = 1'b1;
      bus.op = 5'd10;
      bus.a  = 32'h1234_5678;
      bus.b  = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("reset_mid_busy",
            {bus.in_ready, bus.out_valid, bus.result, bus.equal, bus.less_than,
             bus.less_than_unsigned, dbg_state}, {1'b1, 1'b0, 32'h0, 3'b000, 2'b00});
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [4:0]  ro;
      int guard;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.kill      = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state",
            {bus.in_ready, bus.out_valid, bus.result, bus.equal, bus.less_than,
             bus.less_than_unsigned, dbg_state}, {1'b1, 1'b0, 32'h0, 3'b000, 2'b00});
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      send(5'd0,  32'hFFFF_FFFF, 32'd1,         0);
      send(5'd7,  32'h8000_0000, 32'h24,        0);
      send(5'd11, 32'hFFFF_FFFE, 32'd3,         0);
      send(5'd10, 32'hFFFF_FFFE, 32'd3,         0);
      send(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      send(5'd14, 32'hFFFF_FFF9, 32'd2,         0);
      send(5'd16, 32'hFFFF_FFF9, 32'd2,         0);
      send(5'd15, 32'd100,       32'd7,         0);
      send(5'd17, 32'd100,       32'd7,         0);
      send(5'd14, 32'd5,         32'd0,         0);
      send(5'd17, 32'd5,         32'd0,         0);
      send(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      send(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      send(5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      send(5'd1,  32'd3,         32'd7,         10);

      kill_busy(5'd15, 32'hDEAD_BEEF, 32'd13);
      reset_busy();
      send(5'd0, 32'd2, 32'd3, 0);

      for (int i = 0; i < 60; i++) begin
         ro = 5'($urandom_range(0, 31));
         if (i % 2 == 0) ro = 5'($urandom_range(10, 17));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 20));
            3: ra = 32'h8000_0000;
            4: ra = rb;
            default: ;
         endcase
         send(ro, ra, rb, $urandom_range(0, 2));
      end

      guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         @(posedge clk); #1;
         guard++;
      end
      check("queue_empty", 64'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
